// File: rtl/multicycle_control_if.sv
// Bundle of instruction, multdiv handshake and registered control signals
// exchanged between the fetch/datapath side and the multicycle controller.
// Handshake: an instruction is accepted on a rising edge where
// insn_valid && insn_ready; insn_ready is low (and insn_valid ignored)
// while a multdiv operation is outstanding. md_ready is a single-cycle
// pulse from the multdiv unit and md_exception qualifies only that pulse.
interface multicycle_control_if;
  logic        insn_valid;
  logic [4:0]  opcode;
  logic [4:0]  aluop;
  logic        md_ready;
  logic        md_exception;

  logic        insn_ready;
  logic        stall;
  logic        ctrl_valid;
  logic        rwe;
  logic        dmwe;
  logic        alu_in_sei;
  logic        bne;
  logic        blt;
  logic        bex;
  logic        md_result_sel;
  logic        illegal;
  logic [1:0]  dest_sel;
  logic [1:0]  val_to_write;
  logic [1:0]  pc_sel;
  logic [4:0]  alu_op_out;
  logic        exc_valid;
  logic [31:0] exc_code;
  logic        md_start;
  logic        md_is_div;
  logic        md_abort;
  logic        fsm_state;

  modport slave (
    input  insn_valid, opcode, aluop, md_ready, md_exception,
    output insn_ready, stall, ctrl_valid, rwe, dmwe, alu_in_sei, bne, blt,
           bex, md_result_sel, illegal, dest_sel, val_to_write, pc_sel,
           alu_op_out, exc_valid, exc_code, md_start, md_is_div, md_abort,
           fsm_state
  );

  modport master (
    output insn_valid, opcode, aluop, md_ready, md_exception,
    input  insn_ready, stall, ctrl_valid, rwe, dmwe, alu_in_sei, bne, blt,
           bex, md_result_sel, illegal, dest_sel, val_to_write, pc_sel,
           alu_op_out, exc_valid, exc_code, md_start, md_is_div, md_abort,
           fsm_state
  );
endinterface

// File: rtl/multicycle_control.sv
// Instruction decode controller with a multi-cycle multiply/divide wait.
// Ordinary instructions produce a registered control bundle one cycle after
// acceptance. mult/div start the external multdiv unit and hold fetch until
// it reports a result, an exception, or the wait counter times out.
module multicycle_control #(
  parameter int          MD_TIMEOUT = 40,
  parameter logic [31:0] XCODE_MULT = 32'd4,
  parameter logic [31:0] XCODE_DIV  = 32'd5,
  parameter bit          EXT_DECODE = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  multicycle_control_if.slave bus
);

  typedef enum logic {
    DECODE  = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MD_TIMEOUT);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  typedef struct packed {
    logic       rwe;
    logic       dmwe;
    logic       alu_in_sei;
    logic       bne;
    logic       blt;
    logic       bex;
    logic       illegal;
    logic [1:0] dest_sel;
    logic [1:0] val_to_write;
    logic [1:0] pc_sel;
    logic [4:0] alu_op;
  } dec_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          md_timeout;
  logic          is_md;
  dec_t          dec;

  assign bus.insn_ready = (state == DECODE);
  assign bus.stall      = (state == MD_WAIT) | bus.md_start;
  assign bus.fsm_state  = state;

  // Saturating wait counter; timeout fires when the count would reach the limit.
  always_comb begin
    count_next = (count == CNT_SAT) ? count : count + 1'b1;
    md_timeout = (count_next >= CNT_LIMIT);
  end

  // Opcode decode into the bundle for single-cycle instructions.
  always_comb begin
    dec   = '0;
    is_md = (bus.opcode == 5'd0) && ((bus.aluop == 5'd6) || (bus.aluop == 5'd7));
    case (bus.opcode)
      5'd0: begin
        dec.rwe    = 1'b1;
        dec.alu_op = bus.aluop;
      end
      5'd1: dec.pc_sel = 2'b10;
      5'd2: begin
        dec.bne    = 1'b1;
        dec.pc_sel = 2'b01;
        dec.alu_op = 5'd1;
      end
      5'd3: begin
        dec.rwe          = 1'b1;
        dec.dest_sel     = 2'b01;
        dec.val_to_write = 2'b10;
        dec.pc_sel       = 2'b10;
      end
      5'd4: dec.pc_sel = 2'b11;
      5'd5: begin
        dec.rwe        = 1'b1;
        dec.alu_in_sei = 1'b1;
      end
      5'd6: begin
        dec.blt    = 1'b1;
        dec.pc_sel = 2'b01;
        dec.alu_op = 5'd1;
      end
      5'd7: begin
        dec.dmwe       = 1'b1;
        dec.alu_in_sei = 1'b1;
      end
      5'd8: begin
        dec.rwe          = 1'b1;
        dec.alu_in_sei   = 1'b1;
        dec.val_to_write = 2'b01;
      end
      5'd21: begin
        if (EXT_DECODE) begin
          dec.rwe          = 1'b1;
          dec.dest_sel     = 2'b10;
          dec.val_to_write = 2'b11;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      5'd22: begin
        if (EXT_DECODE) begin
          dec.bex    = 1'b1;
          dec.pc_sel = 2'b10;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // FSM with registered control bundle; pulses default low every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= DECODE;
      count             <= '0;
      bus.ctrl_valid    <= 1'b0;
      bus.rwe           <= 1'b0;
      bus.dmwe          <= 1'b0;
      bus.alu_in_sei    <= 1'b0;
      bus.bne           <= 1'b0;
      bus.blt           <= 1'b0;
      bus.bex           <= 1'b0;
      bus.md_result_sel <= 1'b0;
      bus.illegal       <= 1'b0;
      bus.dest_sel      <= 2'b00;
      bus.val_to_write  <= 2'b00;
      bus.pc_sel        <= 2'b00;
      bus.alu_op_out    <= 5'd0;
      bus.exc_valid     <= 1'b0;
      bus.exc_code      <= 32'd0;
      bus.md_start      <= 1'b0;
      bus.md_is_div     <= 1'b0;
      bus.md_abort      <= 1'b0;
    end else begin
      bus.ctrl_valid    <= 1'b0;
      bus.rwe           <= 1'b0;
      bus.dmwe          <= 1'b0;
      bus.alu_in_sei    <= 1'b0;
      bus.bne           <= 1'b0;
      bus.blt           <= 1'b0;
      bus.bex           <= 1'b0;
      bus.md_result_sel <= 1'b0;
      bus.illegal       <= 1'b0;
      bus.dest_sel      <= 2'b00;
      bus.val_to_write  <= 2'b00;
      bus.pc_sel        <= 2'b00;
      bus.alu_op_out    <= 5'd0;
      bus.exc_valid     <= 1'b0;
      bus.exc_code      <= 32'd0;
      bus.md_start      <= 1'b0;
      bus.md_abort      <= 1'b0;
      case (state)
        DECODE: begin
          if (bus.insn_valid) begin
            if (is_md) begin
              state         <= MD_WAIT;
              count         <= '0;
              bus.md_start  <= 1'b1;
              bus.md_is_div <= (bus.aluop == 5'd7);
            end else begin
              bus.ctrl_valid   <= 1'b1;
              bus.rwe          <= dec.rwe;
              bus.dmwe         <= dec.dmwe;
              bus.alu_in_sei   <= dec.alu_in_sei;
              bus.bne          <= dec.bne;
              bus.blt          <= dec.blt;
              bus.bex          <= dec.bex;
              bus.illegal      <= dec.illegal;
              bus.dest_sel     <= dec.dest_sel;
              bus.val_to_write <= dec.val_to_write;
              bus.pc_sel       <= dec.pc_sel;
              bus.alu_op_out   <= dec.alu_op;
            end
          end
        end
        MD_WAIT: begin
          // A result arriving on the timeout cycle wins over the abort.
          if (bus.md_ready || md_timeout) begin
            state          <= DECODE;
            bus.md_is_div  <= 1'b0;
            bus.ctrl_valid <= 1'b1;
            bus.rwe        <= 1'b1;
            if (bus.md_ready && !bus.md_exception) begin
              bus.md_result_sel <= 1'b1;
            end else begin
              bus.dest_sel     <= 2'b10;
              bus.val_to_write <= 2'b11;
              bus.exc_valid    <= 1'b1;
              bus.exc_code     <= bus.md_is_div ? XCODE_DIV : XCODE_MULT;
              bus.md_abort     <= !bus.md_ready;
            end
          end else begin
            count <= count_next;
          end
        end
        default: state <= DECODE;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MD_TIMEOUT, default 40: maximum MD_WAIT cycles before a multdiv is declared failed (range 1..255).
REQ-002 Parameter XCODE_MULT, default 32'd4: rstatus value written on mult exception or timeout.
REQ-003 Parameter XCODE_DIV, default 32'd5: rstatus value written on div exception or timeout.
REQ-004 Parameter EXT_DECODE, default 1: 1 decodes bex/setx; 0 treats opcodes 21/22 as illegal.
REQ-005 clock  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 insn_valid  in  1  opcode/aluop valid this cycle.
REQ-008 opcode  in  5  instruction opcode.
REQ-009 aluop  in  5  ALU op field, meaningful for opcode 0.
REQ-010 md_ready  in  1  multdiv result ready (single-cycle pulse).
REQ-011 md_exception  in  1  qualifies md_ready, result invalid.
REQ-012 insn_ready  out  1  instruction accepted this cycle.
REQ-013 stall  out  1  fetch/PC hold.
REQ-014 ctrl_valid  out  1  registered control bundle valid (1-cycle pulse).
REQ-015 rwe, dmwe, alu_in_sei, bne, blt, bex, md_result_sel, illegal  out  1 each  registered controls.
REQ-016 dest_sel  out  2  00 rd, 01 r31, 10 r30.
REQ-017 val_to_write  out  2  00 ALU, 01 DMEM, 10 PC+1, 11 status value.
REQ-018 pc_sel  out  2  00 PC+1, 01 PC+1+SEI, 10 target, 11 rd value.
REQ-019 alu_op_out  out  5  ALU operation.
REQ-020 exc_valid  out  1  status value is exc_code, else datapath uses T field.
REQ-021 exc_code  out  32  exception code.
REQ-022 md_start, md_is_div, md_abort  out  1 each  multdiv start pulse, op select, abort pulse.

Function
REQ-023 States DECODE, MD_WAIT; insn_ready = (state==DECODE); stall = (state==MD_WAIT) | md_start.
REQ-024 DECODE with insn_valid: non-multdiv instruction registered; ctrl_valid=1 exactly one cycle later (latency 1); state stays DECODE.
REQ-025 Decode: opcode 0 -> rwe, alu_op_out=aluop; 1 j -> pc_sel=10; 2 bne -> bne, pc_sel=01, alu_op_out=00001; 3 jal -> rwe, dest_sel=01, val_to_write=10, pc_sel=10; 4 jr -> pc_sel=11; 5 addi -> rwe, alu_in_sei, alu_op_out=0; 6 blt -> blt, pc_sel=01, alu_op_out=00001; 7 sw -> dmwe, alu_in_sei, alu_op_out=0; 8 lw -> rwe, alu_in_sei, val_to_write=01, alu_op_out=0.
REQ-026 EXT_DECODE=1: 21 setx -> rwe, dest_sel=10, val_to_write=11, exc_valid=0; 22 bex -> bex, pc_sel=10 (taken-qualification by datapath).
REQ-027 Any other opcode: ctrl_valid=1, illegal=1, all other controls 0.
REQ-028 Unlisted signals in every bundle are 0.
REQ-029 Opcode 0 with aluop 6 (mult) or 7 (div) in DECODE: md_start=1 next cycle for one cycle, md_is_div=(aluop==7) held through MD_WAIT, ctrl_valid=0, enter MD_WAIT, counter cleared.
REQ-030 MD_WAIT: counter increments each cycle, saturating; insn_valid ignored.
REQ-031 md_ready & !md_exception: next cycle ctrl_valid=1, rwe=1, dest_sel=00, val_to_write=00, md_result_sel=1; return to DECODE.
REQ-032 md_ready & md_exception: next cycle ctrl_valid=1, rwe=1, dest_sel=10, val_to_write=11, exc_valid=1, exc_code=XCODE_DIV if md_is_div else XCODE_MULT; return to DECODE.
REQ-033 Counter reaching MD_TIMEOUT without md_ready: md_abort pulse plus REQ-032 bundle same cycle; return to DECODE.
REQ-034 md_ready on the timeout cycle: md_ready wins, no md_abort.
REQ-035 md_ready in DECODE ignored.
REQ-036 Counter width $clog2(MD_TIMEOUT+1).

Reset
REQ-037 reset: state DECODE, counter 0, all outputs 0 except insn_ready=1, same edge; reset during MD_WAIT issues no md_abort and no ctrl_valid.
REQ-038 reset overrides insn_valid and md_ready in the same cycle.

Verification
REQ-039 lw (opcode 8) in DECODE -> next cycle ctrl_valid=1, rwe=1, alu_in_sei=1, val_to_write=01, alu_op_out=0, stall=0.
REQ-040 mult (op 0, aluop 6), md_ready after 10 cycles -> md_start pulse, stall=1 for 11 cycles, then ctrl_valid with md_result_sel=1, dest_sel=00.
REQ-041 div with md_ready&md_exception -> rwe=1, dest_sel=10, val_to_write=11, exc_code=5.
REQ-042 mult, no md_ready, MD_TIMEOUT=40 -> md_abort on wait cycle 40, exc_code=4; md_ready on cycle 40 -> no md_abort, normal bundle.
REQ-043 reset asserted mid MD_WAIT -> next cycle insn_ready=1, all controls 0, no md_abort.
REQ-044 EXT_DECODE=0, opcode 21 -> illegal=1, rwe=0; opcode 31 -> illegal=1 for both settings.
